// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants for the registered stream demultiplexer.
//   DROP_W   - width of the out-of-range drop counter
//   DROP_SAT - value at which the drop counter stops counting
package stream_demux_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = '1;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry pipeline register for a single downstream channel.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - write in_data into the slot this cycle
//   in_data    - payload to store on load
//   out_valid  - slot holds an item
//   out_ready  - consumer accepts the held item this cycle
//   out_data   - held payload (kept after drain until the next load)
//   free       - slot can take a new item this cycle (empty or draining)
//
// Handshake: an item moves across a valid/ready pair exactly on a rising
// clk edge where valid && ready are both 1; valid never depends on ready
// combinationally, and ready may depend on the consumer side only.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // A draining slot is free, so a load can overlap the drain with no bubble.
  assign free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux_reg.sv
// stream_demux_reg: registered 1-to-N_OUT stream demultiplexer.
// Each item on the upstream valid/ready stream is steered to channel up_sel,
// where it sits in that channel's own register, so a stalled channel only
// blocks items addressed to itself.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   up_valid    - upstream item present
//   up_ready    - upstream item accepted when up_valid && up_ready
//   up_data     - upstream payload
//   up_sel      - destination channel of the current item
//   down_valid  - per-channel item present (bit k = channel k)
//   down_ready  - per-channel consumer accept
//   down_data   - packed payloads, channel k at [k*W +: W]
//   drop_cnt    - saturating count of items dropped for out-of-range up_sel
module stream_demux_reg
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int W     = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [W-1:0]       up_data,
  input  logic [SEL_W-1:0]   up_sel,
  output logic [N_OUT-1:0]   down_valid,
  input  logic [N_OUT-1:0]   down_ready,
  output logic [N_OUT*W-1:0] down_data,
  output logic [DROP_W-1:0]  drop_cnt
);

  logic [N_OUT-1:0]  free;
  logic [N_OUT-1:0]  load;
  logic              ready_sel;
  logic [31:0]       sel_ext;
  logic              sel_in_range;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Compare in 32 bits so the test stays meaningful when N_OUT is not a
  // power of two (the select field can then encode non-existent channels).
  assign sel_ext      = 32'(up_sel);
  assign sel_in_range = (sel_ext < 32'(N_OUT));

  // Select decode: only the addressed channel can load, and only if free.
  // up_ready is built from up_sel and slot state only, never from up_valid.
  always_comb begin
    load      = '0;
    ready_sel = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (up_sel == SEL_W'(k)) begin
        ready_sel = free[k];
        load[k]   = up_valid && free[k];
      end
    end
  end

  // Out-of-range items are always taken and discarded.
  assign up_ready = !sel_in_range || ready_sel;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .in_data   (up_data),
      .out_valid (down_valid[g]),
      .out_ready (down_ready[g]),
      .out_data  (down_data[g*W +: W]),
      .free      (free[g])
    );
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (up_valid && !sel_in_range && (drop_cnt_q != DROP_SAT)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
// tb_stream_demux_reg: directed bench for stream_demux_reg, with a 4-channel
// instance for routing/throughput and a 3-channel instance for drops.
module tb_stream_demux_reg;

  logic        clk;
  logic        rst;

  // 4-channel instance
  logic        up_valid;
  logic        up_ready;
  logic [7:0]  up_data;
  logic [1:0]  up_sel;
  logic [3:0]  down_valid;
  logic [3:0]  down_ready;
  logic [31:0] down_data;
  logic [7:0]  drop_cnt;

  // 3-channel instance
  logic        up_valid3;
  logic        up_ready3;
  logic [7:0]  up_data3;
  logic [1:0]  up_sel3;
  logic [2:0]  down_valid3;
  logic [2:0]  down_ready3;
  logic [23:0] down_data3;
  logic [7:0]  drop_cnt3;

  int n_checks;
  int n_fail;

  stream_demux_reg #(.N_OUT(4), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_sel     (up_sel),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .drop_cnt   (drop_cnt)
  );

  stream_demux_reg #(.N_OUT(3), .W(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid3),
    .up_ready   (up_ready3),
    .up_data    (up_data3),
    .up_sel     (up_sel3),
    .down_valid (down_valid3),
    .down_ready (down_ready3),
    .down_data  (down_data3),
    .drop_cnt   (drop_cnt3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    down_ready = 4'b1111;
    step();
    n_checks++;
    if (down_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0000", down_valid);
    end
    n_checks++;
    if (down_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000000", down_data);
    end
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    end
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_up_ready: got %b want 1", up_ready);
    end
    n_checks++;
    if (down_valid3 !== 3'b000 || drop_cnt3 !== 8'd0) begin
      n_fail++; $display("FAIL reset_dut3: valid %b drop %0d want 000 0", down_valid3, drop_cnt3);
    end
  endtask

  task automatic test_route();
    down_ready = 4'b1111;
    up_valid = 1'b1; up_data = 8'hA5; up_sel = 2'd2;
    step();
    n_checks++;
    if (down_valid !== 4'b0100 || down_data[16 +: 8] !== 8'hA5) begin
      n_fail++; $display("FAIL route_ch2: valid %b data %h want 0100 a5", down_valid, down_data[16 +: 8]);
    end
    up_data = 8'h3C; up_sel = 2'd0;
    step();
    n_checks++;
    if (down_valid !== 4'b0001 || down_data[0 +: 8] !== 8'h3C) begin
      n_fail++; $display("FAIL route_ch0: valid %b data %h want 0001 3c", down_valid, down_data[0 +: 8]);
    end
    n_checks++;
    if (down_data[16 +: 8] !== 8'hA5) begin
      n_fail++; $display("FAIL route_hold: ch2 data %h want a5", down_data[16 +: 8]);
    end
    up_valid = 1'b0;
    step();
    n_checks++;
    if (down_valid !== 4'b0000) begin
      n_fail++; $display("FAIL route_drain: valid %b want 0000", down_valid);
    end
  endtask

  task automatic test_backpressure();
    down_ready = 4'b1101;
    up_valid = 1'b1; up_data = 8'h11; up_sel = 2'd1;
    #1;
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_ready: got %b want 1", up_ready);
    end
    step();
    n_checks++;
    if (down_valid !== 4'b0010 || down_data[8 +: 8] !== 8'h11) begin
      n_fail++; $display("FAIL bp_ch1_load: valid %b data %h want 0010 11", down_valid, down_data[8 +: 8]);
    end
    up_data = 8'h22;
    #1;
    n_checks++;
    if (up_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_ready: got %b want 0", up_ready);
    end
    step();
    n_checks++;
    if (down_valid !== 4'b0010 || down_data[8 +: 8] !== 8'h11) begin
      n_fail++; $display("FAIL bp_ch1_hold: valid %b data %h want 0010 11", down_valid, down_data[8 +: 8]);
    end
    // Channel 3 is unaffected by the stalled channel 1.
    up_valid = 1'b0;
    #1;
    up_valid = 1'b1; up_data = 8'h33; up_sel = 2'd3;
    #1;
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ch3_ready: got %b want 1", up_ready);
    end
    step();
    n_checks++;
    if (down_valid !== 4'b1010 || down_data[24 +: 8] !== 8'h33 || down_data[8 +: 8] !== 8'h11) begin
      n_fail++; $display("FAIL bp_ch3_load: valid %b ch3 %h ch1 %h want 1010 33 11", down_valid, down_data[24 +: 8], down_data[8 +: 8]);
    end
    up_data = 8'h22; up_sel = 2'd1;
    #1;
    n_checks++;
    if (up_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_restall_ready: got %b want 0", up_ready);
    end
    down_ready = 4'b1111;
    #1;
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", up_ready);
    end
    step();
    n_checks++;
    if (down_valid !== 4'b0010 || down_data[8 +: 8] !== 8'h22) begin
      n_fail++; $display("FAIL bp_ch1_reload: valid %b data %h want 0010 22", down_valid, down_data[8 +: 8]);
    end
    up_valid = 1'b0;
    step();
    n_checks++;
    if (down_valid !== 4'b0000) begin
      n_fail++; $display("FAIL bp_drain: valid %b want 0000", down_valid);
    end
  endtask

  task automatic test_back_to_back();
    down_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      up_valid = 1'b1; up_data = 8'(i); up_sel = 2'd0;
      #1;
      n_checks++;
      if (up_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, up_ready);
      end
      step();
      n_checks++;
      if (down_valid !== 4'b0001 || down_data[0 +: 8] !== 8'(i)) begin
        n_fail++; $display("FAIL b2b_item[%0d]: valid %b data %h want 0001 %h", i, down_valid, down_data[0 +: 8], 8'(i));
      end
    end
    up_valid = 1'b0;
    step();
    n_checks++;
    if (down_valid !== 4'b0000 || down_data[0 +: 8] !== 8'h07) begin
      n_fail++; $display("FAIL b2b_drain: valid %b data %h want 0000 07", down_valid, down_data[0 +: 8]);
    end
  endtask

  task automatic test_out_of_range();
    down_ready3 = 3'b000;
    up_valid3 = 1'b1; up_data3 = 8'h5A; up_sel3 = 2'd3;
    for (int i = 0; i < 300; i++) begin
      #1;
      n_checks++;
      if (up_ready3 !== 1'b1) begin
        n_fail++; $display("FAIL oor_ready[%0d]: got %b want 1", i, up_ready3);
      end
      step();
      n_checks++;
      if (down_valid3 !== 3'b000) begin
        n_fail++; $display("FAIL oor_valid[%0d]: got %b want 000", i, down_valid3);
      end
      if (i == 9) begin
        n_checks++;
        if (drop_cnt3 !== 8'd10) begin
          n_fail++; $display("FAIL oor_count10: got %0d want 10", drop_cnt3);
        end
      end
    end
    n_checks++;
    if (drop_cnt3 !== 8'd255) begin
      n_fail++; $display("FAIL oor_saturate: got %0d want 255", drop_cnt3);
    end
    up_valid3 = 1'b0;
    step();
    n_checks++;
    if (drop_cnt3 !== 8'd255) begin
      n_fail++; $display("FAIL oor_hold: got %0d want 255", drop_cnt3);
    end
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL oor_pow2_drop: got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_mid_reset();
    down_ready = 4'b1011;
    up_valid = 1'b1; up_data = 8'h77; up_sel = 2'd2;
    step();
    up_valid = 1'b0;
    n_checks++;
    if (down_valid !== 4'b0100 || down_data[16 +: 8] !== 8'h77) begin
      n_fail++; $display("FAIL mr_load: valid %b data %h want 0100 77", down_valid, down_data[16 +: 8]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (down_valid !== 4'b0000 || down_data[16 +: 8] !== 8'h00) begin
      n_fail++; $display("FAIL mr_cleared: valid %b data %h want 0000 00", down_valid, down_data[16 +: 8]);
    end
    n_checks++;
    if (drop_cnt3 !== 8'd0) begin
      n_fail++; $display("FAIL mr_drop_cleared: got %0d want 0", drop_cnt3);
    end
    step();
    n_checks++;
    if (down_valid !== 4'b0000 || down_data !== 32'h0) begin
      n_fail++; $display("FAIL mr_no_replay: valid %b data %h want 0000 00000000", down_valid, down_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    up_valid = 1'b0; up_data = 8'h00; up_sel = 2'd0; down_ready = 4'b0000;
    up_valid3 = 1'b0; up_data3 = 8'h00; up_sel3 = 2'd0; down_ready3 = 3'b000;
    test_reset();
    test_route();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux_reg.md
Name: stream_demux_reg

Overview:
- Registered 1-to-N demultiplexer: the inverse of the mux primitive. One upstream valid/ready stream is steered to one of N downstream valid/ready channels, chosen per item by a select field.
- Each output channel holds its own one-entry pipeline register, so a stalled channel never blocks traffic headed to other channels.
- Sits between a single producer (for example a decoder or arbiter output) and N independent consumers.

Parameters:
- N_OUT, 4, number of downstream channels; legal range 2..16.
- W, 8, payload width in bits.
- SEL_W (localparam), $clog2(N_OUT), width of the select field; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream item present.
- up_ready  output  1  upstream item accepted this cycle when up_valid && up_ready.
- up_data  input  W  upstream payload.
- up_sel  input  SEL_W  destination channel index for the current item.
- down_valid  output  N_OUT  per-channel item present; bit k belongs to channel k.
- down_ready  input  N_OUT  per-channel consumer accepts.
- down_data  output  N_OUT*W  packed payloads; channel k occupies bits [k*W +: W].
- drop_cnt  output  8  saturating count of items dropped because up_sel was out of range.

Behaviour:
- Reset (rst=1 at a clk edge): down_valid=0, down_data=0, drop_cnt=0. up_ready is combinational, so it follows from the cleared state.
- Channel k is free when !down_valid[k] || down_ready[k].
- up_ready = (up_sel >= N_OUT) || free[up_sel]. This is a combinational path from up_sel, down_valid and down_ready. It never depends on up_valid.
- Accept (up_valid && up_ready && up_sel < N_OUT) at edge t: down_data[up_sel] <= up_data and down_valid[up_sel] <= 1, visible at t+1. Latency is 1 cycle.
- Channel k drain (down_valid[k] && down_ready[k]) with no new load into k: down_valid[k] <= 0. down_data[k] holds its last value.
- Simultaneous drain and load on the same channel: the new data loads and down_valid stays 1. This gives full throughput of 1 item per cycle per channel, with no bubble.
- Channel k full and its consumer stalled, with up_sel=k: up_ready=0. Every channel register holds its value. Other channels keep draining independently.
- Out-of-range select (only possible when N_OUT is not a power of 2): up_sel >= N_OUT with up_valid=1 is always accepted and discarded. drop_cnt increments and saturates at 255. No down_valid bit changes because of the dropped item.
- Reset in mid-operation: every pending item is lost. The block restarts from the reset state on the next cycle, and nothing from before reset is replayed.
- Upstream contract: up_data and up_sel stay stable while up_valid=1 && up_ready=0. Violating this is a protocol error, and the block's behaviour in that case is undefined.
- No combinational path from up_valid to up_ready. No combinational path from down_ready to down_valid.

Decomposition:
- Package stream_demux_pkg holds the drop counter width (DROP_W=8) and its saturation value.
- Sub-module demux_slot is one per channel, created with a generate loop. It contains the valid/data register plus the load/drain logic, with ports clk, rst, load, in_data, out_valid, out_ready, out_data, free.
- The top level contains the select decode, the up_ready mux and the drop counter.

Test Plan:
- Reset then idle: rst for 2 cycles, then down_ready=all 1 -> down_valid=0, down_data=0, drop_cnt=0, up_ready=1.
- Route: send 0xA5 with sel=2, then 0x3C with sel=0, down_ready=all 1 -> down_valid=4'b0100 with down_data[2]=0xA5 on the cycle after the first send. Then down_valid=4'b0001 with down_data[0]=0x3C on the next cycle. No other bits set.
- Back-pressure isolation: down_ready[1]=0, send 0x11 to ch1 -> accepted. Send 0x22 to ch1 -> up_ready=0 and ch1 holds 0x11. Send 0x33 to ch3 -> delivered to ch3 one cycle later. Raise down_ready[1] -> 0x22 enters ch1 on that edge.
- Full throughput: 8 back-to-back items to ch0 with values 0..7, down_ready[0]=1 -> up_ready stays 1 throughout. Ch0 shows 0..7 on consecutive cycles with no gap.
- Out-of-range select (N_OUT=3 instance): send 300 items with sel=3 -> all accepted, down_valid stays 0, drop_cnt ends at 255.
- Mid-stream reset: ch2 holding 0x77 with down_ready[2]=0, assert rst for 1 cycle -> down_valid=0 and down_data[2]=0 on the next cycle.
